// File: rtl/job_dispatcher_pkg.sv
// Shared types and sizing for the job dispatcher and its watchdog.
// Holds the state encoding, bus widths and the watchdog limit.
package job_dispatcher_pkg;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 16;
  localparam int SUM_W      = 20;
  localparam int CNT_W      = 5;
  localparam int WDOG_W     = 8;
  localparam int WDOG_LIMIT = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  // A job_count of zero requests a full batch of 16 jobs.
  function automatic logic [CNT_W-1:0] batch_len(input logic [ADDR_W-1:0] jc);
    return (jc == '0) ? CNT_W'(16) : {1'b0, jc};
  endfunction

endpackage

// File: rtl/job_dispatcher_watchdog.sv
// Watchdog for the dispatcher WAIT state: counts consecutive WAIT cycles.
// Latency: expired_o is combinational and rises on the 255th WAIT cycle.
module dispatch_watchdog
  import job_dispatcher_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_wait_i,
  output logic expired_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (in_wait_i) cnt_d = cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = in_wait_i && (cnt_q == WDOG_W'(WDOG_LIMIT - 1));

endmodule

// File: rtl/job_dispatcher.sv
// Batch job dispatcher: per job ISSUE(1) + WAIT(N>=1) + CAPTURE(1) cycles, engine handshake via eng_start/eng_done.
// DISPATCH_TIMEOUT_EN adds a WAIT watchdog that aborts the batch with a sticky timeout_err.
module job_dispatcher
  import job_dispatcher_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] job_count,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_start_address,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_out,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [ADDR_W-1:0] result_addr,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              batch_done,
  output logic              timeout_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0] result_addr_q, result_addr_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              wd_expired;

`ifdef DISPATCH_TIMEOUT_EN
  dispatch_watchdog u_wdog (
    .clk_i     (clk),
    .rst_ni    (reset),
    .in_wait_i (state_q == ST_WAIT),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    result_d      = result_q;
    result_addr_d = result_addr_q;
    sum_d         = sum_q;
    busy_d        = busy_q;
    timeout_d     = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          addr_d    = first_addr;
          remain_d  = batch_len(job_count);
          sum_d     = '0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // A real answer wins over a watchdog expiry landing on the same edge.
        if (eng_done) begin
          result_d      = eng_out;
          result_addr_d = addr_q;
          state_d       = ST_CAPTURE;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_FINISH;
        end
      end
      ST_CAPTURE: begin
        sum_d    = sum_q + SUM_W'(result_q);
        addr_d   = addr_q + ADDR_W'(1);
        remain_d = remain_q - CNT_W'(1);
        state_d  = (remain_q == CNT_W'(1)) ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remain_q      <= '0;
      result_q      <= '0;
      result_addr_q <= '0;
      sum_q         <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      result_q      <= result_d;
      result_addr_q <= result_addr_d;
      sum_q         <= sum_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  assign eng_start         = (state_q == ST_ISSUE);
  assign result_valid      = (state_q == ST_CAPTURE);
  assign batch_done        = (state_q == ST_FINISH);
  assign eng_start_address = addr_q;
  assign result            = result_q;
  assign result_addr       = result_addr_q;
  assign sum               = sum_q;
  assign busy              = busy_q;
  assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_job_dispatcher.sv
// Randomized self-checking bench for job_dispatcher against a batch-level reference model.
module tb_job_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [3:0]  first_addr;
  logic [3:0]  job_count;
  logic        eng_start;
  logic [3:0]  eng_start_address;
  logic        eng_done;
  logic [15:0] eng_out;
  logic [15:0] result;
  logic        result_valid;
  logic [3:0]  result_addr;
  logic [19:0] sum;
  logic        busy;
  logic        batch_done;
  logic        timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  job_dispatcher dut (
    .clk               (clk),
    .reset             (reset),
    .go                (go),
    .first_addr        (first_addr),
    .job_count         (job_count),
    .eng_start         (eng_start),
    .eng_start_address (eng_start_address),
    .eng_done          (eng_done),
    .eng_out           (eng_out),
    .result            (result),
    .result_valid      (result_valid),
    .result_addr       (result_addr),
    .sum               (sum),
    .busy              (busy),
    .batch_done        (batch_done),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_start"},  32'(eng_start), 0);
    chk({tag, "_saddr"},  32'(eng_start_address), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_raddr"},  32'(result_addr), 0);
    chk({tag, "_sum"},    32'(sum), 0);
    chk({tag, "_pulses"}, 32'({result_valid, batch_done}), 0);
    chk({tag, "_tmo"},    32'(timeout_err), 0);
  endtask

  // dmode: 0 = addr*100, 1 = 0xFFFF, 2 = random. fixed_lat 0 = random latency 1..6.
  task automatic run_batch(input logic [3:0] fa, input logic [3:0] jc, input int dmode,
                           input int fixed_lat, input bit noise);
    int n, issued, results, dones, cd, lat, last_start, last_lat, exp_sum, d, last_d;
    logic [3:0] ea;
    logic [15:0] dq[$];
    logic [3:0]  aq[$];
    n = (jc == 0) ? 16 : int'(jc);
    issued = 0; results = 0; dones = 0; cd = 0; lat = 0;
    last_start = -1; last_lat = 0; exp_sum = 0; last_d = 0;
    go = 1'b1; first_addr = fa; job_count = jc; eng_done = 1'b0;
    step;
    go = 1'b0; first_addr = 4'($urandom); job_count = 4'($urandom);
    chk("busy_after_go", 32'(busy), 1);
    chk("timeout_clr_on_go", 32'(timeout_err), 0);
    for (int b = 0; b < 2000 && dones == 0; b++) begin
      if (result_valid) begin
        if (dq.size() == 0) chk("spurious_result_valid", 1, 0);
        else begin
          chk("result", 32'(result), 32'(dq.pop_front()));
          chk("result_addr", 32'(result_addr), 32'(aq.pop_front()));
        end
        results++;
      end
      if (eng_start) begin
        ea = 4'(int'(fa) + issued);
        chk("start_addr", 32'(eng_start_address), 32'(ea));
        if (last_start >= 0) chk("job_latency", 32'(cyc - last_start), 32'(last_lat + 2));
        last_start = cyc;
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        last_lat = lat;
        cd = lat;
        issued++;
        eng_done = noise;
        eng_out = 16'hDEAD;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ea = 4'(int'(fa) + issued - 1);
          d = (dmode == 0) ? int'(ea) * 100 : (dmode == 1) ? 16'hFFFF : int'($urandom_range(0, 16'hFFFF));
          eng_done = 1'b1;
          eng_out = 16'(d);
          dq.push_back(16'(d));
          aq.push_back(ea);
          exp_sum += d;
          last_d = d;
        end else begin
          eng_done = 1'b0;
          eng_out = 16'($urandom);
        end
      end else begin
        eng_done = noise && ($urandom_range(0, 1) == 1);
        eng_out = 16'($urandom);
      end
      if (batch_done) begin
        dones++;
        chk("busy_in_finish", 32'(busy), 1);
      end
      go = noise && !batch_done && ($urandom_range(0, 1) == 1);
      step;
    end
    if (dones == 0) chk("batch_cycle_budget", 0, 1);
    chk("jobs_issued", 32'(issued), 32'(n));
    chk("results_seen", 32'(results), 32'(n));
    chk("sum", 32'(sum), 32'(exp_sum));
    chk("busy_idle", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      eng_done = noise && ($urandom_range(0, 1) == 1);
      eng_out = 16'($urandom);
      step;
      chk("idle_quiet", 32'({eng_start, result_valid, batch_done}), 0);
      chk("result_hold", 32'(result), 32'(last_d));
      chk("sum_hold", 32'(sum), 32'(exp_sum));
    end
    eng_done = 1'b0;
  endtask

  initial begin
    int t, rv, st;
    reset = 1'b0; go = 1'b0; first_addr = '0; job_count = '0;
    eng_done = 1'b0; eng_out = '0;
    step; step;
    chk_all_zero("reset");
    reset = 1'b1;
    step;
    chk("no_start_after_reset", 32'(eng_start), 0);

    run_batch(4'd2,  4'd3, 0, 4, 1'b0);
    run_batch(4'd14, 4'd4, 2, 0, 1'b1);
    run_batch(4'd7,  4'd0, 1, 0, 1'b1);
    for (int k = 0; k < 8; k++)
      run_batch(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 0, 1'b1);

    // Reset in the middle of WAIT clears everything without a clock edge.
    go = 1'b1; first_addr = 4'd5; job_count = 4'd3;
    step;
    go = 1'b0;
    step;
    chk("wait_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step;
    reset = 1'b1;
    st = 0;
    for (int i = 0; i < 10; i++) begin
      eng_done = ($urandom_range(0, 1) == 1);
      step;
      st += int'(eng_start) + int'(busy);
    end
    eng_done = 1'b0;
    chk("no_start_after_mid_reset", 32'(st), 0);
    run_batch(4'd3, 4'd2, 2, 0, 1'b1);

    // Engine never answers.
    go = 1'b1; first_addr = 4'd9; job_count = 4'd2; eng_done = 1'b0;
    step;
    go = 1'b0;
    chk("silent_start", 32'(eng_start), 1);
    t = cyc; rv = 0; st = 0;
`ifdef DISPATCH_TIMEOUT_EN
    for (int i = 0; i < 400 && !batch_done; i++) begin
      step;
      rv += int'(result_valid);
      st += int'(eng_start);
    end
    chk("timeout_done_delay", 32'(cyc - t), 256);
    chk("timeout_err_set", 32'(timeout_err), 1);
    chk("timeout_no_result", 32'(rv), 0);
    chk("timeout_no_restart", 32'(st), 0);
    step;
    chk("timeout_busy_clr", 32'(busy), 0);
    chk("timeout_sticky", 32'(timeout_err), 1);
`else
    for (int i = 0; i < 300; i++) begin
      step;
      rv += int'(result_valid) + int'(batch_done);
      st += int'(timeout_err);
    end
    chk("stall_busy", 32'(busy), 1);
    chk("stall_no_done", 32'(rv), 0);
    chk("stall_no_timeout", 32'(st), 0);
    #2 reset = 1'b0;
    #1;
    chk("stall_reset_busy", 32'(busy), 0);
    step;
    reset = 1'b1;
    step;
`endif
    run_batch(4'd0, 4'd1, 0, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/job_dispatcher.md
JOB_DISPATCHER -- requirements
Module: job_dispatcher

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: go  input  1  request to run a batch; sampled only in IDLE.
REQ-004 SHALL have port: first_addr  input  4  start address of the first job.
REQ-005 SHALL have port: job_count  input  4  number of jobs in the batch; 0 means 16.
REQ-006 SHALL have port: eng_start  output  1  start pulse to the compute engine.
REQ-007 SHALL have port: eng_start_address  output  4  job address presented with eng_start.
REQ-008 SHALL have port: eng_done  input  1  engine completion strobe.
REQ-009 SHALL have port: eng_out  input  16  engine result, valid while eng_done=1.
REQ-010 SHALL have port: result  output  16  last captured engine result.
REQ-011 SHALL have port: result_valid  output  1  one-cycle pulse per captured result.
REQ-012 SHALL have port: result_addr  output  4  job address belonging to result.
REQ-013 SHALL have port: sum  output  20  running sum of the batch's results.
REQ-014 SHALL have port: busy  output  1  high from batch acceptance until batch completion.
REQ-015 SHALL have port: batch_done  output  1  one-cycle pulse at batch end.
REQ-016 SHALL have port: timeout_err  output  1  sticky watchdog error flag; constant 0 without the macro.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT, CAPTURE and FINISH.
REQ-018 IDLE with go=1 SHALL do all of the following: latch first_addr and job_count, clear sum and timeout_err, set busy, and move to ISSUE on the next edge.
REQ-019 ISSUE SHALL assert eng_start for exactly one cycle with eng_start_address equal to the current address, then move to WAIT.
REQ-020 eng_start_address SHALL hold the current address in every state; eng_start SHALL be 0 outside ISSUE.
REQ-021 WAIT SHALL hold until eng_done=1, and SHALL capture eng_out into result and the current address into result_addr on that edge.
REQ-022 CAPTURE SHALL pulse result_valid for one cycle, add result to sum (zero-extended, 20-bit, no overflow possible with 16 jobs), increment the address modulo 16 (15 wraps to 0) and decrement the remaining count.
REQ-023 CAPTURE SHALL move to ISSUE if jobs remain, else to FINISH.
REQ-024 FINISH SHALL pulse batch_done for one cycle, clear busy and return to IDLE.
REQ-025 Latency per job SHALL be 1 (ISSUE) + N (WAIT, N≥1 engine cycles) + 1 (CAPTURE) cycles.
REQ-026 go SHALL be ignored while busy=1.
REQ-027 eng_done SHALL be ignored outside WAIT, including an eng_done in the same cycle as ISSUE.
REQ-028 result, result_addr and sum SHALL hold their values after FINISH until the next batch is accepted.

Reset
REQ-029 Assertion of reset (0) SHALL immediately force IDLE and clear every output, address and count register to 0, including mid-batch.
REQ-030 After reset deassertion, no eng_start SHALL be issued until a new go is accepted.

Configuration
REQ-031 With DISPATCH_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles spent in WAIT; on reaching 255 it SHALL set timeout_err, skip CAPTURE, pulse batch_done and return to IDLE.
REQ-032 Without DISPATCH_TIMEOUT_EN, WAIT SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-033 A shared package SHALL hold the state encoding, the address width (4), the data width (16), the sum width (20) and the watchdog limit (255).
REQ-034 The watchdog SHALL be a sub-module dispatch_watchdog, instantiated only under DISPATCH_TIMEOUT_EN.

Verification
REQ-035 Bench SHALL cover: reset low, then go with first_addr=2, job_count=3, engine returning addr*100 after 4 cycles -> eng_start at addresses 2,3,4; results 200,300,400; sum=900; one batch_done pulse.
REQ-036 Bench SHALL cover: first_addr=14, job_count=4 -> eng_start_address sequence 14,15,0,1 (wrap-around).
REQ-037 Bench SHALL cover: job_count=0 with eng_out=0xFFFF -> 16 jobs and sum=0xFFFF0.
REQ-038 Bench SHALL cover: go pulsed mid-batch and eng_done pulsed during IDLE/ISSUE -> no extra jobs and no spurious result_valid.
REQ-039 Bench SHALL cover: reset asserted during WAIT -> all outputs 0 immediately, busy=0, no eng_start until the next go.
REQ-040 Bench SHALL cover, with DISPATCH_TIMEOUT_EN defined and an engine that never answers: timeout_err=1 and batch_done pulse 255 cycles after entering WAIT.
